// File: rtl/bcd_counter_9999.sv
// bcd_counter_9999: four-digit BCD event counter stepped by a synchronised, edge-detected tick.
// Define UPDOWN_EN to build the down-count (borrow) path selected by the down input.
module bcd_counter_9999 #(
  parameter int MAX_COUNT  = 9999,
  parameter bit BOTH_EDGES = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_in,
  input  logic        start_stop,
  input  logic        clr,
  input  logic        down,
  output logic [3:0]  bcd3,
  output logic [3:0]  bcd2,
  output logic [3:0]  bcd1,
  output logic [3:0]  bcd0,
  output logic [13:0] count_bin,
  output logic        running,
  output logic        wrap
);
  localparam logic [15:0] MAX_BCD = {4'(MAX_COUNT / 1000), 4'(MAX_COUNT / 100 % 10),
                                     4'(MAX_COUNT / 10 % 10), 4'(MAX_COUNT % 10)};
  localparam logic [13:0] MAX_BIN = 14'(MAX_COUNT);
  if (MAX_COUNT < 1 || MAX_COUNT > 9999) begin : g_bad_max
    $error("MAX_COUNT %0d outside 1..9999", MAX_COUNT);
  end
  typedef enum logic {STOP, RUN} state_t;
  state_t state, state_n;
  logic s1, s2, prev, step, hit, adv;
  logic [1:0] arm;
  logic [15:0] cnt, cnt_n;
  logic [13:0] bin_n;
  function automatic logic [15:0] bcd_inc(input logic [15:0] x);
    logic c;
    c = 1'b1;
    for (int i = 0; i < 4; i++)
      if (c) begin
        c = x[4*i +: 4] == 4'd9;
        x[4*i +: 4] = c ? 4'd0 : x[4*i +: 4] + 4'd1;
      end
    return x;
  endfunction
`ifdef UPDOWN_EN
  function automatic logic [15:0] bcd_dec(input logic [15:0] x);
    logic b;
    b = 1'b1;
    for (int i = 0; i < 4; i++)
      if (b) begin
        b = x[4*i +: 4] == 4'd0;
        x[4*i +: 4] = b ? 4'd9 : x[4*i +: 4] - 4'd1;
      end
    return x;
  endfunction
`else
  logic unused_down;
  assign unused_down = down;
`endif
  // step is registered: a tick edge shows up in the count three clocks after it is sampled
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      prev <= 1'b0;
      step <= 1'b0;
      arm <= 2'd0;
    end else begin
      s1 <= tick_in;
      s2 <= s1;
      prev <= s2;
      arm <= arm + {1'b0, arm != 2'd3};
      step <= arm == 2'd3 && (BOTH_EDGES ? s2 ^ prev : s2 && !prev);
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= STOP;
    else state <= state_n;
  always_comb begin
    state_n = start_stop ? (state == RUN ? STOP : RUN) : state;
    adv = state == RUN && step;
    hit = cnt == MAX_BCD;
    cnt_n = hit ? '0 : bcd_inc(cnt);
    bin_n = hit ? '0 : count_bin + 14'd1;
`ifdef UPDOWN_EN
    if (down) begin
      hit = cnt == '0;
      cnt_n = hit ? MAX_BCD : bcd_dec(cnt);
      bin_n = hit ? MAX_BIN : count_bin - 14'd1;
    end
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      count_bin <= '0;
      wrap <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      count_bin <= '0;
      wrap <= 1'b0;
    end else if (adv) begin
      cnt <= cnt_n;
      count_bin <= bin_n;
      wrap <= hit;
    end else wrap <= 1'b0;
  assign {bcd3, bcd2, bcd1, bcd0} = cnt;
  assign running = state == RUN;
endmodule

// File: tb/tb_bcd_counter_9999.sv
// tb_bcd_counter_9999: two instances (9999 rising-edge, 59 both-edge) checked against a count model.
module tb_bcd_counter_9999;
  logic clk = 1'b0, rst = 1'b1, tick_in = 1'b0, start_stop = 1'b0, clr = 1'b0, down = 1'b0;
  logic [3:0] a3, a2, a1, a0, b3, b2, b1, b0;
  logic [13:0] a_bin, b_bin;
  logic a_run, b_run, a_wrap, b_wrap, a_wq = 1'b0, b_wq = 1'b0;
  int checks = 0, failures = 0;
  int mc[2], mw[2], wc[2], mx[2];
  int wlong = 0;
  bit mrun = 1'b0;
  typedef struct {bit ss; bit clr; int n; int e0; int e1; bit er;} vec_t;
  vec_t tv[7];
  always #5 clk = ~clk;
  bcd_counter_9999 u_a (.clk(clk), .rst(rst), .tick_in(tick_in), .start_stop(start_stop), .clr(clr),
    .down(down), .bcd3(a3), .bcd2(a2), .bcd1(a1), .bcd0(a0), .count_bin(a_bin), .running(a_run),
    .wrap(a_wrap));
  bcd_counter_9999 #(.MAX_COUNT(59), .BOTH_EDGES(1'b1)) u_b (.clk(clk), .rst(rst), .tick_in(tick_in),
    .start_stop(start_stop), .clr(clr), .down(down), .bcd3(b3), .bcd2(b2), .bcd1(b1), .bcd0(b0),
    .count_bin(b_bin), .running(b_run), .wrap(b_wrap));
  always @(negedge clk) begin
    wc[0] += int'(a_wrap);
    wc[1] += int'(b_wrap);
    if ((a_wrap && a_wq) || (b_wrap && b_wq)) wlong++;
    a_wq <= a_wrap;
    b_wq <= b_wrap;
  end
  function automatic int va();
    return a3 * 1000 + a2 * 100 + a1 * 10 + a0;
  endfunction
  function automatic int vb();
    return b3 * 1000 + b2 * 100 + b1 * 10 + b0;
  endfunction
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", n, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic model_step(input int i);
    bit dn, w;
`ifdef UPDOWN_EN
    dn = down;
`else
    dn = 1'b0;
`endif
    w = dn ? mc[i] == 0 : mc[i] == mx[i];
    mc[i] = dn ? (w ? mx[i] : mc[i] - 1) : (w ? 0 : mc[i] + 1);
    if (w) mw[i]++;
  endtask
  task automatic set_tick(input logic v);
    if (v !== tick_in && mrun) begin
      if (v) model_step(0);
      model_step(1);
    end
    tick_in = v;
  endtask
  task automatic pulse(input int hi, input int lo);
    set_tick(1'b1);
    cyc(hi);
    set_tick(1'b0);
    cyc(lo);
  endtask
  task automatic pulse_ss();
    start_stop = 1'b1;
    cyc(1);
    start_stop = 1'b0;
    mrun = !mrun;
  endtask
  task automatic pulse_clr();
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    mc = '{0, 0};
  endtask
  task automatic check_all(input string t);
    chk({t, " a_bcd"}, va(), mc[0]);
    chk({t, " a_bin"}, int'(a_bin), mc[0]);
    chk({t, " b_bcd"}, vb(), mc[1]);
    chk({t, " b_bin"}, int'(b_bin), mc[1]);
    chk({t, " a_run"}, int'(a_run), int'(mrun));
    chk({t, " b_run"}, int'(b_run), int'(mrun));
    chk({t, " a_wraps"}, wc[0], mw[0]);
    chk({t, " b_wraps"}, wc[1], mw[1]);
  endtask
  task automatic do_reset(input logic t);
    rst = 1'b1;
    mc = '{0, 0};
    mrun = 1'b0;
    tick_in = t;
    cyc(2);
    chk("rst a_bcd", va(), 0);
    chk("rst a_bin", int'(a_bin), 0);
    chk("rst a_run", int'(a_run), 0);
    chk("rst a_wrap", int'(a_wrap), 0);
    chk("rst b_bcd", vb(), 0);
    rst = 1'b0;
    cyc(4);
  endtask
  initial begin
    int w0, e6;
    mx = '{9999, 59};
    mc = '{0, 0};
    mw = '{0, 0};
    wc = '{0, 0};
    tv[0] = '{1'b1, 1'b0, 0, 0, 0, 1'b1};
    tv[1] = '{1'b0, 1'b0, 12, 12, 24, 1'b1};
    tv[2] = '{1'b0, 1'b0, 20, 32, 4, 1'b1};
    tv[3] = '{1'b1, 1'b0, 3, 32, 4, 1'b0};
    tv[4] = '{1'b0, 1'b1, 0, 0, 0, 1'b0};
    tv[5] = '{1'b1, 1'b0, 5, 5, 10, 1'b1};
    tv[6] = '{1'b0, 1'b1, 2, 2, 4, 1'b1};
    // tick held high through reset must not produce a step
    do_reset(1'b1);
    pulse_ss();
    cyc(10);
    chk("held a_bcd", va(), 0);
    chk("held b_bcd", vb(), 0);
    chk("held run", int'(a_run), 1);
    do_reset(1'b0);
    foreach (tv[i]) begin
      if (tv[i].ss) pulse_ss();
      if (tv[i].clr) pulse_clr();
      repeat (tv[i].n) pulse(4, 4);
      cyc(4);
      chk($sformatf("tv%0d a_bcd", i), va(), tv[i].e0);
      chk($sformatf("tv%0d b_bcd", i), vb(), tv[i].e1);
      chk($sformatf("tv%0d run", i), int'(a_run), int'(tv[i].er));
      check_all($sformatf("tv%0d", i));
    end
    // start_stop in the step cycle: step counts, then stop
    pulse_clr();
    repeat (9) pulse(4, 4);
    cyc(4);
    chk("t4 pre", va(), 9);
    set_tick(1'b1);
    cyc(3);
    chk("t4 latency hold", va(), 9);
    start_stop = 1'b1;
    cyc(1);
    start_stop = 1'b0;
    mrun = 1'b0;
    chk("t4 latency step", va(), 10);
    cyc(4);
    chk("t4 stopped", int'(a_run), 0);
    set_tick(1'b0);
    cyc(4);
    pulse(4, 4);
    cyc(4);
    chk("t4 held", va(), 10);
    check_all("t4");
    // clr together with step
    pulse_ss();
    pulse_clr();
    repeat (123) pulse(4, 4);
    cyc(4);
    chk("t5 pre", va(), 123);
    w0 = wc[0];
    set_tick(1'b1);
    cyc(3);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    mc = '{0, 0};
    cyc(4);
    chk("t5 clr", va(), 0);
    chk("t5 no wrap", wc[0] - w0, 0);
    chk("t5 run", int'(a_run), 1);
    check_all("t5");
    set_tick(1'b0);
    repeat (3) pulse(4, 4);
    #2 rst = 1'b1;
    #1;
    chk("midrst a_bcd", va(), 0);
    chk("midrst a_bin", int'(a_bin), 0);
    chk("midrst a_run", int'(a_run), 0);
    chk("midrst b_bcd", vb(), 0);
    mc = '{0, 0};
    mrun = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(4);
    // down input at 0100
    pulse_ss();
    repeat (100) pulse(4, 4);
    cyc(4);
    chk("t6 pre", va(), 100);
    down = 1'b1;
`ifdef UPDOWN_EN
    e6 = 99;
`else
    e6 = 101;
`endif
    pulse(4, 4);
    cyc(4);
    chk("t6 down", va(), e6);
`ifdef UPDOWN_EN
    pulse_clr();
    pulse(4, 4);
    cyc(4);
    chk("t6 borrow wrap", va(), 9999);
`endif
    check_all("t6");
    down = 1'b0;
    // terminal count 9999 rollover
    pulse_clr();
    repeat (9999) pulse(1, 1);
    cyc(4);
    chk("t3 at max", va(), 9999);
    check_all("t3 pre");
    w0 = wc[0];
    pulse(4, 4);
    cyc(4);
    chk("t3 wrap", va(), 0);
    chk("t3 wrap pulses", wc[0] - w0, 1);
    check_all("t3");
    for (int k = 0; k < 200; k++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: set_tick(!tick_in);
        3: pulse_ss();
        4: pulse_clr();
        default: down = $urandom_range(0, 1) == 1;
      endcase
      cyc(6);
      check_all($sformatf("rnd%0d", k));
    end
    chk("wrap width", wlong, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
